lzc_norm_pipe: RTL

Pipelined leading-zero/leading-one counter and normaliser for arbitrary `WIDTH`, with per-transaction mode select and valid/ready flow control on both sides. It returns the leading count and the input left-shifted by that count (mantissa normalisation), plus a pass-through tag. It is the streaming front end for the floating-point pack/convert paths, replacing ad-hoc combinational counters that required power-of-two widths and had no backpressure.

---
 rtl/lzc_pkg.sv | 28 ++
 rtl/lzc_seg.sv | 44 ++++
 rtl/lzc_norm_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lzc_pkg.sv
// lzc_pkg: sizing helpers and mode encodings shared by the leading-count
// normaliser and its segment counters.
package lzc_pkg;

    localparam logic LZC_MODE_ZEROS = 1'b0;
    localparam logic LZC_MODE_ONES  = 1'b1;

    // Bits needed to hold a count in the range 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Number of segments, rounding up so a partial top segment is counted.
    function automatic int num_seg(input int width, input int seg_w);
        return (width + seg_w - 1) / seg_w;
    endfunction

    // Width of the MSB-aligned top segment; a full segment when seg_w divides width.
    function automatic int top_seg_w(input int width, input int seg_w);
        return ((width % seg_w) == 0) ? seg_w : (width % seg_w);
    endfunction

    // Distance in bits from the MSB of the word to the MSB of segment k.
    function automatic int seg_offset(input int width, input int seg_w, input int k);
        return (k == 0) ? 0 : (top_seg_w(width, seg_w) + (k - 1) * seg_w);
    endfunction

endpackage

// File: rtl/lzc_seg.sv
// lzc_seg: combinational leading-zero count over one segment. The caller
// inverts the data beforehand for leading-ones mode, so this block only ever
// looks for the first set bit from the MSB end.
module lzc_seg #(
    parameter int    W      = 16,
    parameter int    CW     = 5,
    parameter string FAMILY = "Agilex"
) (
    input  logic [W-1:0]  seg_data,
    output logic [CW-1:0] seg_count,
    output logic          seg_all
);

    generate
        if (FAMILY == "Stratix 10") begin : g_s10
            // Scan LSB upward; the last set bit seen is the leading one.
            always_comb begin
                seg_count = CW'(W);
                for (int i = 0; i < W; i++) begin
                    if (seg_data[i]) begin
                        seg_count = CW'(W - 1 - i);
                    end
                end
            end
        end else begin : g_agilex
            logic found;

            // Scan MSB downward and latch onto the first set bit found.
            always_comb begin
                seg_count = CW'(W);
                found     = 1'b0;
                for (int i = W - 1; i >= 0; i--) begin
                    if (!found && seg_data[i]) begin
                        seg_count = CW'(W - 1 - i);
                        found     = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign seg_all = ~|seg_data;

endmodule

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage leading-zero/leading-one counter and normaliser
// with valid/ready on both sides. S1 registers per-segment counts, S2 picks
// the first segment that is not all-zero and barrel-shifts the operand.
module lzc_norm_pipe
    import lzc_pkg::*;
#(
    parameter int    WIDTH  = 64,
    parameter int    TAG_W  = 8,
    parameter int    SEG_W  = 16,
    parameter string FAMILY = "Agilex",
    localparam int   CNT_W  = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_all,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSEG = num_seg(WIDTH, SEG_W);
    localparam int SCW  = cnt_w(SEG_W);
    localparam int TOPW = top_seg_w(WIDTH, SEG_W);

    logic                      s1_v;
    logic                      s2_v;
    logic [NSEG-1:0][SCW-1:0]  s1_cnt;
    logic [NSEG-1:0]           s1_all;
    logic [WIDTH-1:0]          s1_data;
    logic [TAG_W-1:0]          s1_tag;

    logic [WIDTH-1:0]          s1_src;
    logic [NSEG-1:0][SCW-1:0]  seg_cnt;
    logic [NSEG-1:0]           seg_all;

    logic                      s2_open;
    logic                      in_fire;
    logic                      s1_move;

    logic [CNT_W-1:0]          s2_cnt_d;
    logic [WIDTH-1:0]          s2_norm_d;
    logic                      s2_all_d;

    // S2 can take new data when it is empty or its result leaves this cycle;
    // S1 can then take new data when it is empty or it moves into S2.
    assign s2_open  = !s2_v || out_ready;
    assign in_ready = !s1_v || s2_open;
    assign in_fire  = in_valid && in_ready;
    assign s1_move  = s1_v && s2_open;

    // Leading-ones mode reuses the zero counters on the inverted operand.
    assign s1_src = in_data ^ {WIDTH{in_mode == LZC_MODE_ONES}};

    generate
        for (genvar k = 0; k < NSEG; k++) begin : g_seg
            localparam int SW = (k == 0) ? TOPW : SEG_W;
            localparam int HI = WIDTH - 1 - seg_offset(WIDTH, SEG_W, k);

            lzc_seg #(
                .W      (SW),
                .CW     (SCW),
                .FAMILY (FAMILY)
            ) u_seg (
                .seg_data  (s1_src[HI -: SW]),
                .seg_count (seg_cnt[k]),
                .seg_all   (seg_all[k])
            );
        end
    endgenerate

    // Stage occupancy: S1 refills or drains, S2 follows S1 whenever it is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= in_fire || (s1_v && !s2_open);
            if (s2_open) begin
                s2_v <= s1_v;
            end
        end
    end

    // S1 payload: segment counts, segment-empty flags and the raw operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cnt  <= '0;
            s1_all  <= '0;
            s1_data <= '0;
            s1_tag  <= '0;
        end else if (in_fire) begin
            s1_cnt  <= seg_cnt;
            s1_all  <= seg_all;
            s1_data <= in_data;
            s1_tag  <= in_tag;
        end
    end

    // Pick the most significant segment that still holds a set bit.
    always_comb begin
        s2_cnt_d = CNT_W'(WIDTH);
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (!s1_all[k]) begin
                s2_cnt_d = CNT_W'(seg_offset(WIDTH, SEG_W, k)) + CNT_W'(s1_cnt[k]);
            end
        end
    end

    assign s2_norm_d = s1_data << s2_cnt_d;
    assign s2_all_d  = &s1_all;

    // S2 result registers, which are the block outputs and hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
            out_norm  <= '0;
            out_all   <= 1'b0;
            out_tag   <= '0;
        end else if (s1_move) begin
            out_count <= s2_cnt_d;
            out_norm  <= s2_norm_d;
            out_all   <= s2_all_d;
            out_tag   <= s1_tag;
        end
    end

    assign out_valid = s2_v;

endmodule
